// File: rtl/tl_a_pkg.sv
// tl_a_pkg: shared TileLink-UL A-channel opcodes, field bundle and beat geometry
package tl_a_pkg;

    localparam int BEAT_LOG_DEF = 3;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    // Field bundle at the default widths (SRC_W 7, ADDR_W 12, 8-byte beat)
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [6:0]  source;
        logic [11:0] address;
        logic [7:0]  mask;
        logic        corrupt;
    } tl_a_bits_t;

endpackage

// File: rtl/tl_beat_counter.sv
// tl_beat_counter: beat index within a request plus the last-beat decode
module tl_beat_counter
    import tl_a_pkg::*;
#(
    parameter int BEAT_LOG = BEAT_LOG_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fire,
    input  logic       single,
    input  logic [2:0] size,
    output logic [3:0] beat,
    output logic       last
);

    localparam logic [3:0] BL = 4'(BEAT_LOG);

    logic [3:0] size_w;
    logic [3:0] lg;
    logic [3:0] top;

    assign size_w = {1'b0, size};
    assign lg     = (single || size_w <= BL) ? 4'd0 : size_w - BL;
    assign top    = 4'((5'd1 << lg) - 5'd1);
    assign last   = beat == top;

    // Advance on every accepted beat, wrapping to zero after the final one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            beat <= 4'd0;
        else if (fire)
            beat <= last ? 4'd0 : beat + 4'd1;
    end

endmodule

// File: rtl/tl_a_fragmenter.sv
// tl_a_fragmenter: splits multi-beat A-channel requests into beat-sized requests
module tl_a_fragmenter
    import tl_a_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SRC_W    = 7,
    parameter int BEAT_LOG = BEAT_LOG_DEF,
    parameter int MAX_SIZE = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       io_repeat,
    output logic                       io_in_ready,
    input  logic                       io_in_valid,
    input  logic [2:0]                 io_in_bits_opcode,
    input  logic [2:0]                 io_in_bits_param,
    input  logic [2:0]                 io_in_bits_size,
    input  logic [SRC_W-1:0]           io_in_bits_source,
    input  logic [ADDR_W-1:0]          io_in_bits_address,
    input  logic [(1<<BEAT_LOG)-1:0]   io_in_bits_mask,
    input  logic                       io_in_bits_corrupt,
    input  logic                       io_out_ready,
    output logic                       io_out_valid,
    output logic [2:0]                 io_out_bits_opcode,
    output logic [2:0]                 io_out_bits_param,
    output logic [2:0]                 io_out_bits_size,
    output logic [SRC_W-1:0]           io_out_bits_source,
    output logic [ADDR_W-1:0]          io_out_bits_address,
    output logic [(1<<BEAT_LOG)-1:0]   io_out_bits_mask,
    output logic                       io_out_bits_corrupt,
    output logic                       io_out_last,
    output logic [3:0]                 io_out_beat,
    output logic                       io_err
);

    localparam logic [3:0] BL = 4'(BEAT_LOG);
    localparam logic [3:0] MS = 4'(MAX_SIZE);

    logic [3:0] size_w;
    logic       is_get;
    logic       is_put;
    logic       too_big;
    logic       multi;
    logic       fire;
    logic [3:0] beat;
    logic       last;

    assign size_w  = {1'b0, io_in_bits_size};
    assign is_get  = io_in_bits_opcode == OP_GET;
    assign is_put  = io_in_bits_opcode == OP_PUT_FULL || io_in_bits_opcode == OP_PUT_PARTIAL;
    assign too_big = size_w > MS;
    // Only legal Gets and Puts wider than a beat are re-addressed and re-sized
    assign multi   = (is_get || is_put) && !too_big && size_w > BL;
    assign fire    = io_in_valid && io_out_ready;

    tl_beat_counter #(.BEAT_LOG(BEAT_LOG)) u_beat (
        .clock (clock),
        .reset (reset),
        .fire  (fire),
        .single(!multi),
        .size  (io_in_bits_size),
        .beat  (beat),
        .last  (last)
    );

    assign io_in_ready         = io_out_ready;
    assign io_out_valid        = io_in_valid;
    // Only a Get is replayed by the repeater; Put bursts already arrive beat by beat
    assign io_repeat           = io_in_valid && is_get && multi && !last;
    assign io_out_bits_opcode  = io_in_bits_opcode;
    assign io_out_bits_param   = io_in_bits_param;
    assign io_out_bits_source  = io_in_bits_source;
    assign io_out_bits_size    = multi ? 3'(BEAT_LOG) : io_in_bits_size;
    assign io_out_bits_address = multi
        ? (io_in_bits_address & ({ADDR_W{1'b1}} << io_in_bits_size)) | (ADDR_W'(beat) << BEAT_LOG)
        : io_in_bits_address;
    assign io_out_bits_mask    = (multi && is_get) ? '1 : io_in_bits_mask;
    assign io_out_bits_corrupt = io_in_bits_corrupt || too_big;
    assign io_out_last         = last;
    assign io_out_beat         = beat;

    // One-cycle error pulse following acceptance of an oversized request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            io_err <= 1'b0;
        else
            io_err <= fire && too_big;
    end

endmodule
